// File: rtl/servo_pkg.sv
// Shared types and constants for the servo command decoder.
// Holds the packet FSM states, command codes and ack encodings.
package servo_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GOT_HDR,
      GOT_CMD,
      GOT_PAY
   } state_t;

   localparam logic [7:0] PKT_HDR    = 8'hA5;
   localparam logic [7:0] CMD_SPEED0 = 8'h00;
   localparam logic [7:0] CMD_SPEED1 = 8'h01;
   localparam logic [7:0] CMD_STEP0  = 8'h02;
   localparam logic [7:0] CMD_STEP1  = 8'h03;
   localparam logic [7:0] CMD_STOP   = 8'h04;
   localparam logic [7:0] ACK_ERR    = 8'h7F;

   function automatic logic [7:0] ack_ok(input logic [7:0] cmd);
      return {1'b1, 4'b0000, cmd[2:0]};
   endfunction

endpackage

// File: rtl/servo_ack_fifo.sv
// 4-deep ack byte queue with a valid/ready output side.
// Pushes arriving while full are silently dropped.
module servo_ack_fifo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] push_data,
   output logic [7:0] ack_data,
   output logic       ack_valid,
   input  logic       ack_ready
);

   logic [7:0] mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic       do_push;
   logic       do_pop;

   assign ack_valid = (count != 3'd0);
   assign ack_data  = mem[rd_ptr];
   assign do_pop    = ack_valid && ack_ready;
   assign do_push   = push && (count != 3'd4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 2'd1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/servo_cmd_decoder.sv
// Byte-stream packet decoder driving servo speed/step with a link watchdog.
// Define SERVO_CMD_ACK_EN to add the ack byte FIFO and its ports.
module servo_cmd_decoder
   import servo_pkg::*;
#(
   parameter logic [31:0] BYTE_TIMEOUT  = 32'd100000,
   parameter logic [31:0] LINK_TIMEOUT  = 32'd50000000,
   parameter logic [2:0]  NEUTRAL_STEP  = 3'd4,
   parameter logic [7:0]  NEUTRAL_SPEED = 8'd128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       servo_0_speed_write_en,
   output logic       servo_1_speed_write_en,
   output logic [7:0] servo_0_speed,
   output logic [7:0] servo_1_speed,
   output logic [2:0] servo_0_step,
   output logic [2:0] servo_1_step,
   output logic       link_ok,
   output logic [7:0] err_count
`ifdef SERVO_CMD_ACK_EN
   ,
   output logic [7:0] ack_data,
   output logic       ack_valid,
   input  logic       ack_ready
`endif
);

   state_t      state;
   logic [7:0]  cmd;
   logic [7:0]  pay;
   logic [31:0] byte_cnt;
   logic [31:0] link_cnt;
   logic        pkt_end;
   logic        pkt_good;
   logic        pkt_ok;
   logic        pkt_bad;
   logic        byte_to;
   logic        wd_hit;
   logic        stop_now;

   assign pkt_end  = rx_valid && (state == GOT_PAY);
   assign pkt_good = (rx_data == (cmd ^ pay)) && (cmd <= CMD_STOP);
   assign pkt_ok   = pkt_end && pkt_good;
   assign pkt_bad  = pkt_end && !pkt_good;
   assign byte_to  = (state != IDLE) && !rx_valid
                     && (byte_cnt >= BYTE_TIMEOUT - 32'd1);
   // A packet landing on the expiry cycle pre-empts the watchdog stop.
   assign wd_hit   = !pkt_ok && (link_cnt == LINK_TIMEOUT - 32'd1);
   assign stop_now = (pkt_ok && (cmd == CMD_STOP)) || wd_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                  <= IDLE;
         cmd                    <= 8'h00;
         pay                    <= 8'h00;
         byte_cnt               <= 32'd0;
         link_cnt               <= 32'd0;
         link_ok                <= 1'b0;
         err_count              <= 8'h00;
         servo_0_speed          <= NEUTRAL_SPEED;
         servo_1_speed          <= NEUTRAL_SPEED;
         servo_0_step           <= NEUTRAL_STEP;
         servo_1_step           <= NEUTRAL_STEP;
         servo_0_speed_write_en <= 1'b0;
         servo_1_speed_write_en <= 1'b0;
      end else begin
         servo_0_speed_write_en <= 1'b0;
         servo_1_speed_write_en <= 1'b0;

         if (rx_valid || state == IDLE || byte_to) byte_cnt <= 32'd0;
         else byte_cnt <= byte_cnt + 32'd1;

         if (rx_valid) begin
            unique case (state)
               IDLE: if (rx_data == PKT_HDR) state <= GOT_HDR;
               GOT_HDR: begin
                  cmd   <= rx_data;
                  state <= GOT_CMD;
               end
               GOT_CMD: begin
                  pay   <= rx_data;
                  state <= GOT_PAY;
               end
               default: state <= IDLE;
            endcase
         end else if (byte_to) begin
            state <= IDLE;
         end

         if ((pkt_bad || byte_to) && err_count != 8'hFF)
            err_count <= err_count + 8'd1;

         if (pkt_ok) begin
            link_cnt <= 32'd0;
            link_ok  <= 1'b1;
            unique case (1'b1)
               (cmd == CMD_SPEED0): begin
                  servo_0_speed          <= pay;
                  servo_0_speed_write_en <= 1'b1;
               end
               (cmd == CMD_SPEED1): begin
                  servo_1_speed          <= pay;
                  servo_1_speed_write_en <= 1'b1;
               end
               (cmd == CMD_STEP0): servo_0_step <= pay[2:0];
               (cmd == CMD_STEP1): servo_1_step <= pay[2:0];
               default: ;
            endcase
         end else if (link_cnt != LINK_TIMEOUT) begin
            link_cnt <= link_cnt + 32'd1;
            if (wd_hit) link_ok <= 1'b0;
         end

         if (stop_now) begin
            servo_0_speed          <= NEUTRAL_SPEED;
            servo_1_speed          <= NEUTRAL_SPEED;
            servo_0_step           <= NEUTRAL_STEP;
            servo_1_step           <= NEUTRAL_STEP;
            servo_0_speed_write_en <= 1'b1;
            servo_1_speed_write_en <= 1'b1;
         end
      end
   end

`ifdef SERVO_CMD_ACK_EN
   servo_ack_fifo u_ack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (pkt_end),
      .push_data (pkt_ok ? ack_ok(cmd) : ACK_ERR),
      .ack_data  (ack_data),
      .ack_valid (ack_valid),
      .ack_ready (ack_ready)
   );
`endif

endmodule

// File: doc/servo_cmd_decoder.md
Name: servo_cmd_decoder

Overview:
- Upstream neighbour of the servo control stage.
- Parses a byte stream from the UART receiver into servo commands: speed write pulses, 8-bit speed values and 3-bit step values for servo 0 and servo 1.
- Adds a link watchdog that parks both servos at neutral when no valid packet arrives in time.
- Its outputs drive the control stage's speed, write-enable and step inputs directly.

Parameters:
- BYTE_TIMEOUT, 32'd100000, idle cycles allowed between bytes of one packet before the partial packet is discarded.
- LINK_TIMEOUT, 32'd50000000, cycles without a valid packet before the watchdog forces neutral.
- NEUTRAL_STEP, 3'd4, step value giving zero drift in the control stage (4*50000/256 ≈ 781).
- NEUTRAL_SPEED, 8'd128, mid-range speed written on stop/watchdog.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe, rx_data valid
- servo_0_speed_write_en  output  1  one-cycle pulse, servo_0_speed updated
- servo_1_speed_write_en  output  1  one-cycle pulse, servo_1_speed updated
- servo_0_speed  output  8  registered speed, servo 0
- servo_1_speed  output  8  registered speed, servo 1
- servo_0_step  output  3  registered step, servo 0
- servo_1_step  output  3  registered step, servo 1
- link_ok  output  1  high while the watchdog has not expired
- err_count  output  8  saturating count of rejected packets

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - servo_0_speed and servo_1_speed = NEUTRAL_SPEED.
  - servo_0_step and servo_1_step = NEUTRAL_STEP.
  - Both write_en outputs = 0.
  - link_ok = 0, err_count = 0.
  - FSM in IDLE; both timers cleared.
- Packet format: 0xA5, CMD, PAYLOAD, CHK, where CHK = CMD ^ PAYLOAD.
- FSM states: IDLE -> GOT_HDR -> GOT_CMD -> GOT_PAY -> (check on CHK byte) -> IDLE.
  - IDLE: advances only on a byte equal to 0xA5; any other byte is ignored and not counted as an error.
  - Every other state advances on each rx_valid.
- Commands (applied in the cycle after the CHK byte is accepted; latency from CHK strobe to outputs = 1 cycle):
  - 0x00: servo_0_speed = PAYLOAD; pulse servo_0_speed_write_en for 1 cycle.
  - 0x01: same for servo 1.
  - 0x02: servo_0_step = PAYLOAD[2:0].
  - 0x03: servo_1_step = PAYLOAD[2:0].
  - 0x04: stop. Both speeds = NEUTRAL_SPEED, both steps = NEUTRAL_STEP, both write_en pulse together.
- Rejected packets: a CHK mismatch or an unknown CMD (>0x04) discards the packet, increments err_count (saturates at 8'hFF) and returns to IDLE. No outputs change.
- Byte timeout: a counter runs in any state except IDLE and clears on each rx_valid. When it reaches BYTE_TIMEOUT, the FSM returns to IDLE and err_count increments.
- Watchdog:
  - Counter clears on every accepted packet (including stop) and sets link_ok = 1 on the same cycle.
  - Otherwise it increments, saturating at LINK_TIMEOUT.
  - On the cycle it first reaches LINK_TIMEOUT: link_ok falls and a stop action is applied once (not repeated while expired).
- Simultaneous events:
  - An accepted packet on the same cycle as watchdog expiry wins: the packet is applied, the watchdog clears, no stop is issued.
  - Byte timeout and rx_valid on the same cycle: rx_valid wins and the byte is processed.
- Write pulses are never longer than 1 cycle; back-to-back packets may produce pulses separated by a minimum of 4 cycles.
- Reset mid-packet aborts immediately; no partial update is ever applied.

Optional Feature:
- Macro: SERVO_CMD_ACK_EN.
- With it:
  - Extra ports: ack_data (8, out), ack_valid (1, out), ack_ready (1, in).
  - Each accepted packet queues ack byte {1'b1, 4'b0, CMD[2:0]}; each rejected packet queues 8'h7F.
  - Uses a 4-entry FIFO; ack_valid holds until ack_ready is sampled high.
  - When the FIFO is full, new acks are dropped and command processing is unaffected.
  - Reset empties the FIFO and clears ack_valid.
- Without it: no ack ports and no FIFO logic.

Decomposition:
- Shared package servo_pkg holds:
  - the FSM state enum;
  - constants PKT_HDR = 8'hA5;
  - command codes CMD_SPEED0, CMD_SPEED1, CMD_STEP0, CMD_STEP1, CMD_STOP;
  - ACK_ERR = 8'h7F.
- One natural sub-module: servo_ack_fifo (4-deep, valid/ready), instantiated only under SERVO_CMD_ACK_EN.

Test Plan:
- Bytes A5,00,C8,C8 → 1 cycle after CHK: servo_0_speed = 8'hC8, servo_0_speed_write_en high exactly 1 cycle, link_ok = 1, err_count = 0.
- Bytes A5,03,06,05 → servo_1_step = 3'd6, no write_en pulses. Then A5,01,10,00 (bad CHK) → servo_1_speed unchanged, err_count = 1.
- Bytes A5,02 then silence for BYTE_TIMEOUT (set to 16) → FSM in IDLE, err_count increments. Then a full valid packet is accepted normally.
- LINK_TIMEOUT = 64, one valid packet, then silence → at cycle 64 link_ok = 0, both write_en pulse once, speeds = 128, steps = 4. No further pulses over the next 200 cycles.
- Assert rst_n low between PAYLOAD and CHK → all outputs return to reset values asynchronously. CHK sent after release is ignored (not 0xA5).
- With SERVO_CMD_ACK_EN and ack_ready held low: 5 valid packets → FIFO holds 4 acks, 5th dropped. Raise ack_ready → 4 bytes 8'h80 | CMD emitted in order.
